aes_prng_clearing_mshare: RTL and testbench
===========================================

AES_PRNG_CLEARING_MSHARE -- requirements
Module: aes_prng_clearing_mshare

Interface
REQ-001 Parameter Width, default 64: LFSR/output width; SHALL be a multiple of 4 and of EntropyWidth, range 32..256.
REQ-002 Parameter EntropyWidth, default 32: entropy bus width.
REQ-003 Parameter NumShares, default 2: output shares, range 1..4.
REQ-004 Parameter ReseedInterval, default 0: granted data requests before an automatic reseed; 0 disables automatic reseed.
REQ-005 Parameter SecSkipPRNGReseeding, default 0: 1 bypasses all reseeding.
REQ-006 Parameter RndCnstLfsrSeed, default nonzero Width-bit constant: reset/fallback LFSR state.
REQ-007 Port clk_i  input  1  clock; single clock domain.
REQ-008 Port rst_i  input  1  reset, asynchronous, active-high.
REQ-009 Port data_req_i  input  1  consumer requests fresh data.
REQ-010 Port data_ack_o  output  1  request granted this cycle.
REQ-011 Port data_o  output  NumShares x Width  pseudo-random shares.
REQ-012 Port reseed_req_i  input  1  consumer requests reseed; held until ack.
REQ-013 Port reseed_ack_o  output  1  one-cycle reseed completion pulse.
REQ-014 Port entropy_req_o  output  1  entropy word requested.
REQ-015 Port entropy_ack_i  input  1  entropy_i valid, word consumed.
REQ-016 Port entropy_i  input  EntropyWidth  entropy word.
REQ-017 Port seed_zero_o  output  1  sticky: an all-zero packed seed was replaced by RndCnstLfsrSeed.

Function
REQ-018 FSM states IDLE, COLLECT, SEED; reset state IDLE.
REQ-019 IDLE -> COLLECT when reseed_req_i=1 or auto_due=1 (SecSkipPRNGReseeding=0); else stay.
REQ-020 COLLECT: entropy_req_o=1; each entropy_ack_i stores entropy_i into word slot wcnt (word 0 in LSBs), wcnt increments; after Width/EntropyWidth words -> SEED, wcnt=0.
REQ-021 SEED (one cycle): LFSR loads packed seed, or RndCnstLfsrSeed if packed seed is zero (sets seed_zero_o); reseed_ack_o=1 iff reseed_req_i=1; grant counter cleared, auto_due cleared; -> IDLE.
REQ-022 entropy_ack_i outside COLLECT SHALL be ignored; entropy_req_o=0 outside COLLECT.
REQ-023 data_ack_o = data_req_i & state==IDLE & ~reseed_req_i & ~auto_due (combinational); reseed has priority over data.
REQ-024 LFSR: Galois XOR, Width bits, advances exactly one step per cycle with data_ack_o=1; holds otherwise.
REQ-025 scr = PRINCE 4-bit S-box applied to every nibble of LFSR state (S = B,F,3,2,A,C,9,1,6,7,8,0,E,5,D,4).
REQ-026 data_o[k] = scr rotated left by k*(Width/NumShares) bits (floor division), k = 0..NumShares-1; combinational from LFSR state.
REQ-027 Grant counter (ceil(log2(ReseedInterval+1)) bits) increments per data_ack_o; reaching ReseedInterval sets auto_due next cycle; the grant that reaches the interval is honoured.
REQ-028 Automatic reseed SHALL complete without reseed_ack_o unless reseed_req_i is high in SEED.
REQ-029 SecSkipPRNGReseeding=1: FSM stays IDLE, entropy_req_o=0, reseed_ack_o=reseed_req_i, auto_due never set, LFSR never reseeded.
REQ-030 reseed_req_i deasserted during COLLECT: collection SHALL still complete and seed; no ack.

Reset
REQ-031 rst_i asserted at any time: state IDLE, wcnt 0, grant counter 0, auto_due 0, seed_zero_o 0, LFSR = RndCnstLfsrSeed, partial seed words discarded; all request/ack outputs 0 (except data_ack_o per REQ-023 combinationally).
REQ-032 First cycle after reset release SHALL accept data_req_i.

Verification (Width=64, EntropyWidth=32, NumShares=2)
REQ-033 Reseed with words 0x11111111 then 0x22222222 -> reseed_ack_o one pulse the cycle after second ack; data_o[0]=0x33333333FFFFFFFF, data_o[1]=0xFFFFFFFF33333333.
REQ-034 Reseed with two zero words -> LFSR = RndCnstLfsrSeed, seed_zero_o=1 until reset.
REQ-035 data_req_i and reseed_req_i both high in IDLE -> data_ack_o=0, entropy_req_o=1 next cycle, LFSR unchanged.
REQ-036 ReseedInterval=3, data_req_i held high -> exactly 3 acks, then entropy_req_o=1, no reseed_ack_o after seeding, acks resume.
REQ-037 rst_i asserted after one of two entropy words -> after release state IDLE, entropy_req_o=0, data_o[0]=sbox(RndCnstLfsrSeed).
REQ-038 SecSkipPRNGReseeding=1, reseed_req_i=1 -> reseed_ack_o=1 same cycle, entropy_req_o stays 0.

Source files
------------

// File: rtl/aes_prng_clearing_mshare.sv
// Masked-share PRNG for clearing datapath registers. A Galois LFSR is
// scrambled through the PRINCE S-box and rotated into NumShares outputs.
// Reseeding collects Width bits of entropy, either on request or
// automatically after ReseedInterval granted data requests.
module aes_prng_clearing_mshare #(
  parameter int unsigned      Width                = 64,
  parameter int unsigned      EntropyWidth         = 32,
  parameter int unsigned      NumShares            = 2,
  parameter int unsigned      ReseedInterval       = 0,
  parameter bit               SecSkipPRNGReseeding = 1'b0,
  parameter logic [Width-1:0] RndCnstLfsrSeed      =
    Width'(256'h8F1C2B7DE04693A5C3D217B05E8A694F0123456789ABCDEFF0E1D2C3B4A59687)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 data_req_i,
  output logic                                 data_ack_o,
  output logic [NumShares-1:0][Width-1:0]      data_o,
  input  logic                                 reseed_req_i,
  output logic                                 reseed_ack_o,
  output logic                                 entropy_req_o,
  input  logic                                 entropy_ack_i,
  input  logic [EntropyWidth-1:0]              entropy_i,
  output logic                                 seed_zero_o
);

  localparam int unsigned NumWords = Width / EntropyWidth;
  localparam int unsigned WcntW    = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int unsigned GcntW    = (ReseedInterval > 0) ? $clog2(ReseedInterval + 1) : 1;
  localparam logic [WcntW-1:0] LastWord    = WcntW'(NumWords - 1);
  localparam logic [GcntW-1:0] IntervalVal = GcntW'(ReseedInterval);
  localparam bit AutoEn = (ReseedInterval > 0) && !SecSkipPRNGReseeding;

  // Feedback taps: known maximal-length polynomials for the common widths,
  // a simple dense fallback otherwise.
  localparam int unsigned TapA = (Width == 32) ? 21 : (Width == 64) ? 62 :
                                 (Width == 128) ? 125 : (Width == 256) ? 253 : Width - 2;
  localparam int unsigned TapB = (Width == 32) ? 1 : (Width == 64) ? 60 :
                                 (Width == 128) ? 100 : (Width == 256) ? 250 : Width - 3;
  localparam int unsigned TapC = (Width == 32) ? 0 : (Width == 64) ? 59 :
                                 (Width == 128) ? 98 : (Width == 256) ? 245 : Width - 4;
  localparam logic [Width-1:0] Taps = (Width'(1) << (Width - 1)) | (Width'(1) << TapA) |
                                      (Width'(1) << TapB) | (Width'(1) << TapC);

  // PRINCE S-box, element i holds S(i).
  localparam logic [15:0][3:0] SboxLut = {4'h4, 4'hD, 4'h5, 4'hE, 4'h0, 4'h8, 4'h7, 4'h6,
                                          4'h1, 4'h9, 4'hC, 4'hA, 4'h2, 4'h3, 4'hF, 4'hB};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SEED    = 2'd2
  } state_e;

  state_e                                state_q, state_d;
  logic   [WcntW-1:0]                    wcnt_q;
  logic   [NumWords-1:0][EntropyWidth-1:0] seed_buf_q;
  logic   [Width-1:0]                    packed_seed;
  logic   [GcntW-1:0]                    gcnt_q;
  logic                                  auto_due_q;
  logic   [Width-1:0]                    lfsr_q;
  logic   [Width-1:0]                    scr;
  logic                                  seed_load;

  assign packed_seed = seed_buf_q;
  assign data_ack_o  = data_req_i & (state_q == IDLE) & ~reseed_req_i & ~auto_due_q;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs; reseed requests are acked directly when reseeding is skipped.
  always_comb begin
    state_d       = state_q;
    entropy_req_o = 1'b0;
    reseed_ack_o  = 1'b0;
    seed_load     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!SecSkipPRNGReseeding && (reseed_req_i || auto_due_q)) state_d = COLLECT;
      end
      COLLECT: begin
        entropy_req_o = 1'b1;
        if (entropy_ack_i && (wcnt_q == LastWord)) state_d = SEED;
      end
      SEED: begin
        seed_load    = 1'b1;
        reseed_ack_o = reseed_req_i;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (SecSkipPRNGReseeding) reseed_ack_o = reseed_req_i;
  end

  // Entropy collection: word 0 lands in the least significant slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wcnt_q     <= '0;
      seed_buf_q <= '0;
    end else if ((state_q == COLLECT) && entropy_ack_i) begin
      seed_buf_q[wcnt_q] <= entropy_i;
      wcnt_q             <= (wcnt_q == LastWord) ? '0 : wcnt_q + 1'b1;
    end
  end

  // Grant counter: the grant reaching the interval is served, then auto_due blocks further grants.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gcnt_q     <= '0;
      auto_due_q <= 1'b0;
    end else if (seed_load) begin
      gcnt_q     <= '0;
      auto_due_q <= 1'b0;
    end else if (AutoEn && data_ack_o) begin
      gcnt_q <= gcnt_q + 1'b1;
      if ((gcnt_q + 1'b1) == IntervalVal) auto_due_q <= 1'b1;
    end
  end

  // LFSR: load a fresh seed (never all-zero), otherwise step once per granted request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q      <= RndCnstLfsrSeed;
      seed_zero_o <= 1'b0;
    end else if (seed_load) begin
      if (packed_seed == '0) begin
        lfsr_q      <= RndCnstLfsrSeed;
        seed_zero_o <= 1'b1;
      end else begin
        lfsr_q <= packed_seed;
      end
    end else if (data_ack_o) begin
      lfsr_q <= {1'b0, lfsr_q[Width-1:1]} ^ (lfsr_q[0] ? Taps : '0);
    end
  end

  // Nibble-wise S-box scrambling of the LFSR state.
  always_comb begin
    scr = '0;
    for (int i = 0; i < int'(Width / 4); i++) begin
      scr[4*i +: 4] = SboxLut[lfsr_q[4*i +: 4]];
    end
  end

  for (genvar k = 0; k < NumShares; k++) begin : g_share
    localparam int unsigned Sh = k * (Width / NumShares);
    if (Sh == 0) begin : g_plain
      assign data_o[k] = scr;
    end else begin : g_rot
      assign data_o[k] = (scr << Sh) | (scr >> (Width - Sh));
    end
  end

endmodule

// File: tb/tb_aes_prng_clearing_mshare.sv
// Scoreboard bench for aes_prng_clearing_mshare: three instances cover
// request-driven reseeding, automatic reseeding and the skip-reseed build.
module tb_aes_prng_clearing_mshare;

  localparam logic [63:0] Seed      = 64'h0123456789ABCDEF;
  localparam logic [63:0] ScrSeed0  = 64'hBF32AC916780E5D4;
  localparam logic [63:0] ScrSeed1  = 64'h6780E5D4BF32AC91;
  localparam logic [63:0] ScrStep0  = 64'h567F8302EA5CD941;
  localparam logic [63:0] ScrStep1  = 64'hEA5CD941567F8302;
  localparam logic [63:0] ScrStep20 = 64'h0AA65FC7D3984210;
  localparam logic [63:0] ScrStep21 = 64'hD39842100AA65FC7;
  localparam logic [63:0] Scr12_0   = 64'h33333333FFFFFFFF;
  localparam logic [63:0] Scr12_1   = 64'hFFFFFFFF33333333;
  localparam logic [63:0] Scr12s_0  = 64'hE7FFFFFFB6666666;
  localparam logic [63:0] Scr12s_1  = 64'hB6666666E7FFFFFF;

  typedef struct packed {
    logic [63:0] d0;
    logic [63:0] d1;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             dreq_b = 0, rreq_b = 0, eack_b = 0, dack_b, rack_b, ereq_b, zero_b;
  logic [31:0]      ent_b = '0;
  logic [1:0][63:0] data_b;
  logic             dreq_a = 0, rreq_a = 0, eack_a = 0, dack_a, rack_a, ereq_a, zero_a;
  logic [31:0]      ent_a = '0;
  logic [1:0][63:0] data_a;
  logic             dreq_s = 0, rreq_s = 0, eack_s = 0, dack_s, rack_s, ereq_s, zero_s;
  logic [31:0]      ent_s = '0;
  logic [1:0][63:0] data_s;

  exp_t q_b[$];
  exp_t q_a[$];
  exp_t q_s[$];
  int   checks = 0;
  int   errors = 0;
  int   rs_b_seen = 0, rs_a_seen = 0, rs_b_exp = 0;

  aes_prng_clearing_mshare #(.Width(64), .EntropyWidth(32), .NumShares(2), .ReseedInterval(0),
    .SecSkipPRNGReseeding(1'b0), .RndCnstLfsrSeed(Seed)) u_base (
    .clk_i(clk), .rst_i(rst), .data_req_i(dreq_b), .data_ack_o(dack_b), .data_o(data_b),
    .reseed_req_i(rreq_b), .reseed_ack_o(rack_b), .entropy_req_o(ereq_b),
    .entropy_ack_i(eack_b), .entropy_i(ent_b), .seed_zero_o(zero_b));

  aes_prng_clearing_mshare #(.Width(64), .EntropyWidth(32), .NumShares(2), .ReseedInterval(3),
    .SecSkipPRNGReseeding(1'b0), .RndCnstLfsrSeed(Seed)) u_auto (
    .clk_i(clk), .rst_i(rst), .data_req_i(dreq_a), .data_ack_o(dack_a), .data_o(data_a),
    .reseed_req_i(rreq_a), .reseed_ack_o(rack_a), .entropy_req_o(ereq_a),
    .entropy_ack_i(eack_a), .entropy_i(ent_a), .seed_zero_o(zero_a));

  aes_prng_clearing_mshare #(.Width(64), .EntropyWidth(32), .NumShares(2), .ReseedInterval(0),
    .SecSkipPRNGReseeding(1'b1), .RndCnstLfsrSeed(Seed)) u_skip (
    .clk_i(clk), .rst_i(rst), .data_req_i(dreq_s), .data_ack_o(dack_s), .data_o(data_s),
    .reseed_req_i(rreq_s), .reseed_ack_o(rack_s), .entropy_req_o(ereq_s),
    .entropy_ack_i(eack_s), .entropy_i(ent_s), .seed_zero_o(zero_s));

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic dreq, input logic rreq, input logic eack,
                               input logic [31:0] ent);
    dreq_b = dreq;
    rreq_b = rreq;
    eack_b = eack;
    ent_b  = ent;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every granted data request pops and checks the next expected share pair.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (dack_b) begin
        if (q_b.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL base_unexpected_ack: got ack with %h, expected none", data_b[0]);
        end else begin
          e = q_b.pop_front();
          checkOutput("base_share0", data_b[0], e.d0);
          checkOutput("base_share1", data_b[1], e.d1);
        end
      end
      if (dack_a) begin
        if (q_a.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL auto_unexpected_ack: got ack with %h, expected none", data_a[0]);
        end else begin
          e = q_a.pop_front();
          checkOutput("auto_share0", data_a[0], e.d0);
          checkOutput("auto_share1", data_a[1], e.d1);
        end
      end
      if (dack_s) begin
        if (q_s.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL skip_unexpected_ack: got ack with %h, expected none", data_s[0]);
        end else begin
          e = q_s.pop_front();
          checkOutput("skip_share0", data_s[0], e.d0);
          checkOutput("skip_share1", data_s[1], e.d1);
        end
      end
      if (rack_b) rs_b_seen++;
      if (rack_a) rs_a_seen++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    $display("[TB] starting");
    // Request-driven instance: data and reseed together, reseed wins.
    applyReset();
    applyStimulus(1, 1, 0, 32'h0);
    rs_b_exp++;
    @(negedge clk);
    checkOutput("reset_seed_zero", 64'(zero_b), 64'd0);
    checkOutput("reset_share0", data_b[0], ScrSeed0);
    checkOutput("reset_share1", data_b[1], ScrSeed1);
    checkOutput("prio_data_ack", 64'(dack_b), 64'd0);
    checkOutput("prio_entropy_req_idle", 64'(ereq_b), 64'd0);
    tick(); applyStimulus(0, 1, 0, 32'h0);
    @(negedge clk);
    checkOutput("prio_entropy_req", 64'(ereq_b), 64'd1);
    checkOutput("prio_lfsr_held", data_b[0], ScrSeed0);
    tick(); applyStimulus(0, 1, 1, 32'h11111111);
    tick(); applyStimulus(0, 1, 1, 32'h22222222);
    tick(); applyStimulus(0, 1, 0, 32'h0);
    @(negedge clk);
    checkOutput("seed_reseed_ack", 64'(rack_b), 64'd1);
    checkOutput("seed_entropy_req", 64'(ereq_b), 64'd0);
    tick(); applyStimulus(1, 0, 0, 32'h0);
    q_b.push_back('{Scr12_0, Scr12_1});
    @(negedge clk);
    checkOutput("reseed_ack_single", 64'(rack_b), 64'd0);
    tick(); applyStimulus(1, 0, 0, 32'h0);
    q_b.push_back('{Scr12s_0, Scr12s_1});
    // Stray entropy ack in IDLE, then an all-zero seed.
    tick(); applyStimulus(0, 0, 1, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("idle_entropy_req", 64'(ereq_b), 64'd0);
    tick(); applyStimulus(0, 1, 0, 32'h0);
    rs_b_exp++;
    tick(); applyStimulus(0, 1, 1, 32'h0);
    tick(); applyStimulus(0, 1, 1, 32'h0);
    tick(); applyStimulus(0, 1, 0, 32'h0);
    @(negedge clk);
    checkOutput("zero_reseed_ack", 64'(rack_b), 64'd1);
    tick(); applyStimulus(1, 0, 0, 32'h0);
    q_b.push_back('{ScrSeed0, ScrSeed1});
    @(negedge clk);
    checkOutput("zero_seed_flag", 64'(zero_b), 64'd1);
    tick(); applyStimulus(0, 0, 0, 32'h0);
    // Request withdrawn during collection: seeding still happens, no ack.
    tick(); applyStimulus(0, 1, 0, 32'h0);
    tick(); applyStimulus(0, 0, 1, 32'h11111111);
    tick(); applyStimulus(0, 0, 1, 32'h22222222);
    tick(); applyStimulus(0, 0, 0, 32'h0);
    @(negedge clk);
    checkOutput("withdrawn_no_ack", 64'(rack_b), 64'd0);
    tick(); applyStimulus(1, 0, 0, 32'h0);
    q_b.push_back('{Scr12_0, Scr12_1});
    @(negedge clk);
    checkOutput("seed_zero_sticky", 64'(zero_b), 64'd1);
    tick(); applyStimulus(0, 0, 0, 32'h0);
    // Reset after one of two entropy words.
    tick(); applyStimulus(0, 1, 0, 32'h0);
    tick(); applyStimulus(0, 1, 1, 32'h55555555);
    tick(); applyStimulus(0, 0, 0, 32'h0);
    applyReset();
    @(negedge clk);
    checkOutput("midreset_entropy_req", 64'(ereq_b), 64'd0);
    checkOutput("midreset_seed_zero", 64'(zero_b), 64'd0);
    checkOutput("midreset_share0", data_b[0], ScrSeed0);
    tick(); applyStimulus(0, 1, 0, 32'h0);
    rs_b_exp++;
    tick(); applyStimulus(0, 1, 1, 32'h11111111);
    tick(); applyStimulus(0, 1, 1, 32'h22222222);
    tick(); applyStimulus(0, 1, 0, 32'h0);
    @(negedge clk);
    checkOutput("post_reset_reseed_ack", 64'(rack_b), 64'd1);
    tick(); applyStimulus(1, 0, 0, 32'h0);
    q_b.push_back('{Scr12_0, Scr12_1});
    tick(); applyStimulus(0, 0, 0, 32'h0);

    // Automatic reseed every 3 grants, data request held from reset.
    dreq_a = 1'b1;
    q_a.push_back('{ScrSeed0, ScrSeed1});
    q_a.push_back('{ScrStep0, ScrStep1});
    q_a.push_back('{ScrStep20, ScrStep21});
    applyReset();
    @(negedge clk);
    checkOutput("auto_first_cycle_ack", 64'(dack_a), 64'd1);
    tick(); tick(); tick();
    @(negedge clk);
    checkOutput("auto_due_blocks", 64'(dack_a), 64'd0);
    checkOutput("auto_due_idle_ereq", 64'(ereq_a), 64'd0);
    tick();
    eack_a = 1'b1; ent_a = 32'h11111111;
    @(negedge clk);
    checkOutput("auto_collect_ereq", 64'(ereq_a), 64'd1);
    tick(); ent_a = 32'h22222222;
    tick(); eack_a = 1'b0; ent_a = '0;
    @(negedge clk);
    checkOutput("auto_seed_no_ack", 64'(rack_a), 64'd0);
    checkOutput("auto_seed_no_data", 64'(dack_a), 64'd0);
    tick();
    q_a.push_back('{Scr12_0, Scr12_1});
    q_a.push_back('{Scr12s_0, Scr12s_1});
    @(negedge clk);
    checkOutput("auto_resume_ack", 64'(dack_a), 64'd1);
    tick(); tick(); dreq_a = 1'b0;

    // Skip-reseed build: reseed acknowledged immediately, no entropy traffic.
    applyReset();
    rreq_s = 1'b1;
    @(negedge clk);
    checkOutput("skip_ack_same_cycle", 64'(rack_s), 64'd1);
    checkOutput("skip_ereq_0", 64'(ereq_s), 64'd0);
    tick();
    @(negedge clk);
    checkOutput("skip_ereq_1", 64'(ereq_s), 64'd0);
    tick(); rreq_s = 1'b0;
    @(negedge clk);
    checkOutput("skip_ack_drop", 64'(rack_s), 64'd0);
    checkOutput("skip_lfsr_kept", data_s[0], ScrSeed0);
    tick(); dreq_s = 1'b1;
    q_s.push_back('{ScrSeed0, ScrSeed1});
    tick(); dreq_s = 1'b0;
    tick(); tick();

    checkOutput("base_queue_empty", 64'(q_b.size()), 64'd0);
    checkOutput("auto_queue_empty", 64'(q_a.size()), 64'd0);
    checkOutput("skip_queue_empty", 64'(q_s.size()), 64'd0);
    checkOutput("base_reseed_acks", 64'(rs_b_seen), 64'(rs_b_exp));
    checkOutput("auto_reseed_acks", 64'(rs_a_seen), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
